// File: rtl/ysyx_24090013_bus_arbiter.sv
// rtl/ysyx_24090013_bus_arbiter.sv - round-robin arbiter sharing one slave port among NR_REQ requesters
module ysyx_24090013_bus_arbiter #(
    parameter int  NR_REQ = 2,
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    localparam int ID_W   = (NR_REQ > 2) ? $clog2(NR_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NR_REQ-1:0]        m_req_valid,
    output logic [NR_REQ-1:0]        m_req_ready,
    input  logic [NR_REQ*ADDR_W-1:0] m_req_addr,
    input  logic [NR_REQ*DATA_W-1:0] m_req_wdata,
    input  logic [NR_REQ-1:0]        m_req_wen,
    output logic [NR_REQ-1:0]        m_resp_valid,
    output logic [DATA_W-1:0]        m_resp_rdata,
    output logic                     s_req_valid,
    input  logic                     s_req_ready,
    output logic [ADDR_W-1:0]        s_req_addr,
    output logic [DATA_W-1:0]        s_req_wdata,
    output logic                     s_req_wen,
    input  logic                     s_resp_valid,
    input  logic [DATA_W-1:0]        s_resp_rdata,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

    localparam logic [NR_REQ-1:0] ONE_HOT0 = NR_REQ'(1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NR_REQ-1:0]   resp_valid_q, resp_valid_d;

    logic                found;
    logic [ID_W-1:0]     winner;
    logic                resp_done;

    // Rotating priority search starting at ptr_q, wrapping without a modulo.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NR_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NR_REQ) begin
                idx = idx - NR_REQ;
            end
            if (!found && m_req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        rdata_d      = rdata_q;
        resp_valid_d = '0;
        resp_done    = 1'b0;
        m_req_ready  = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    if (!reset) begin
                        m_req_ready[winner] = 1'b1;
                    end
                    grant_d = winner;
                    addr_d  = m_req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d = m_req_wdata[int'(winner)*DATA_W +: DATA_W];
                    wen_d   = m_req_wen[winner];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (s_req_ready) begin
                    if (s_resp_valid) begin
                        resp_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (s_resp_valid) begin
                    resp_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Response completes the transaction and advances the round-robin pointer.
        if (resp_done) begin
            resp_valid_d = ONE_HOT0 << grant_q;
            rdata_d      = s_resp_rdata;
            state_d      = ST_IDLE;
            ptr_d        = (grant_q == ID_W'(NR_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            rdata_q      <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign s_req_valid  = (state_q == ST_ISSUE);
    assign s_req_addr   = addr_q;
    assign s_req_wdata  = wdata_q;
    assign s_req_wen    = wen_q;
    assign m_resp_valid = resp_valid_q;
    assign m_resp_rdata = rdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_ysyx_24090013_bus_arbiter.sv
// tb/tb_ysyx_24090013_bus_arbiter.sv - directed vector bench for the round-robin bus arbiter
module tb_ysyx_24090013_bus_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Two-requester instance: req0 reads 0x8000_0000, req1 writes 0x12345678 to 0x1000.
    logic        a_rst;
    logic [1:0]  a_valid, a_mrdy, a_rv, a_wen;
    logic [63:0] a_addr, a_wdata;
    logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
    logic        a_sv, a_srdy, a_swen, a_sresp, a_busy;
    logic [0:0]  a_gid;

    assign a_addr  = {32'h0000_1000, 32'h8000_0000};
    assign a_wdata = {32'h1234_5678, 32'h0000_0000};
    assign a_wen   = 2'b10;

    ysyx_24090013_bus_arbiter #(.NR_REQ(2), .ADDR_W(32), .DATA_W(32)) u_a (
        .clock(clock), .reset(a_rst),
        .m_req_valid(a_valid), .m_req_ready(a_mrdy), .m_req_addr(a_addr),
        .m_req_wdata(a_wdata), .m_req_wen(a_wen),
        .m_resp_valid(a_rv), .m_resp_rdata(a_rdata),
        .s_req_valid(a_sv), .s_req_ready(a_srdy), .s_req_addr(a_saddr),
        .s_req_wdata(a_swdata), .s_req_wen(a_swen),
        .s_resp_valid(a_sresp), .s_resp_rdata(a_srdata),
        .busy(a_busy), .grant_id(a_gid)
    );

    // Three-requester instance for wrap-around of the pointer.
    logic        b_rst;
    logic [2:0]  b_valid, b_mrdy, b_rv, b_wen;
    logic [95:0] b_addr, b_wdata;
    logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
    logic        b_sv, b_srdy, b_swen, b_sresp, b_busy;
    logic [1:0]  b_gid;

    assign b_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    assign b_wdata = {32'd2, 32'd1, 32'd0};
    assign b_wen   = 3'b000;

    ysyx_24090013_bus_arbiter #(.NR_REQ(3), .ADDR_W(32), .DATA_W(32)) u_b (
        .clock(clock), .reset(b_rst),
        .m_req_valid(b_valid), .m_req_ready(b_mrdy), .m_req_addr(b_addr),
        .m_req_wdata(b_wdata), .m_req_wen(b_wen),
        .m_resp_valid(b_rv), .m_resp_rdata(b_rdata),
        .s_req_valid(b_sv), .s_req_ready(b_srdy), .s_req_addr(b_saddr),
        .s_req_wdata(b_swdata), .s_req_wen(b_swen),
        .s_resp_valid(b_sresp), .s_resp_rdata(b_srdata),
        .busy(b_busy), .grant_id(b_gid)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic        srdy;
        logic        sresp;
        logic [31:0] srdata;
        logic [1:0]  e_mrdy;
        logic [1:0]  e_rv;
        logic        e_sv;
        logic        e_busy;
        logic        e_gid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] vld, input logic srdy,
                                input logic sresp, input logic [31:0] srdata,
                                input logic [1:0] e_mrdy, input logic [1:0] e_rv,
                                input logic e_sv, input logic e_busy, input logic e_gid,
                                input logic [31:0] e_rdata);
        vec_t v;
        v.rst = rst; v.vld = vld; v.srdy = srdy; v.sresp = sresp; v.srdata = srdata;
        v.e_mrdy = e_mrdy; v.e_rv = e_rv; v.e_sv = e_sv; v.e_busy = e_busy;
        v.e_gid = e_gid; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic b_serve(input logic [2:0] vld, input int idx, input logic [31:0] rd, input int step);
        logic [2:0]  oh;
        logic [31:0] ea;
        oh = 3'b001 << idx;
        ea = 32'h100 * (idx + 1);
        @(negedge clock);
        b_valid = vld;
        #1;
        chk("b_grant_ready", step, 64'(b_mrdy), 64'(oh));
        @(negedge clock);
        b_valid = 3'b000;
        b_srdy  = 1'b1;
        #1;
        chk("b_s_req_valid", step, 64'(b_sv), 64'(1'b1));
        chk("b_s_req_addr", step, 64'(b_saddr), 64'(ea));
        chk("b_grant_id", step, 64'(b_gid), 64'(idx));
        @(negedge clock);
        b_srdy   = 1'b0;
        b_sresp  = 1'b1;
        b_srdata = rd;
        @(negedge clock);
        b_sresp = 1'b0;
        #1;
        chk("b_resp_valid", step, 64'(b_rv), 64'(oh));
        chk("b_resp_rdata", step, 64'(b_rdata), 64'(rd));
    endtask

    initial begin
        logic [31:0] addr_c[2];
        logic [31:0] wdata_c[2];
        logic        wen_c[2];
        addr_c[0] = 32'h8000_0000; wdata_c[0] = 32'h0;         wen_c[0] = 1'b0;
        addr_c[1] = 32'h0000_1000; wdata_c[1] = 32'h1234_5678; wen_c[1] = 1'b1;

        a_rst = 1'b0; a_valid = '0; a_srdy = 1'b0; a_sresp = 1'b0; a_srdata = '0;
        b_rst = 1'b0; b_valid = '0; b_srdy = 1'b0; b_sresp = 1'b0; b_srdata = '0;
        #2;
        a_rst = 1'b1;
        b_rst = 1'b1;

        //           rst vld  rdy rsp rdata          mrdy  rv   sv bsy gid  rdata
        vq.push_back(mk(1, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 2'b01, 0, 0, 32'h0,        2'b01, 2'b00, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 2'b00, 1, 0, 32'h0,        2'b00, 2'b00, 1, 1, 0, 32'h0));
        vq.push_back(mk(0, 2'b00, 0, 1, 32'hDEADBEEF, 2'b00, 2'b00, 0, 1, 0, 32'h0));
        vq.push_back(mk(0, 2'b00, 0, 0, 32'h0,        2'b00, 2'b01, 0, 0, 0, 32'hDEADBEEF));
        vq.push_back(mk(0, 2'b11, 0, 0, 32'h0,        2'b10, 2'b00, 0, 0, 0, 32'hDEADBEEF));
        vq.push_back(mk(0, 2'b11, 1, 0, 32'h0,        2'b00, 2'b00, 1, 1, 1, 32'hDEADBEEF));
        vq.push_back(mk(0, 2'b11, 0, 1, 32'h11111111, 2'b00, 2'b00, 0, 1, 1, 32'hDEADBEEF));
        vq.push_back(mk(0, 2'b11, 0, 0, 32'h0,        2'b01, 2'b10, 0, 0, 1, 32'h11111111));
        vq.push_back(mk(0, 2'b11, 1, 0, 32'h0,        2'b00, 2'b00, 1, 1, 0, 32'h11111111));
        vq.push_back(mk(0, 2'b11, 0, 1, 32'h22222222, 2'b00, 2'b00, 0, 1, 0, 32'h11111111));
        vq.push_back(mk(0, 2'b11, 0, 0, 32'h0,        2'b10, 2'b01, 0, 0, 0, 32'h22222222));
        vq.push_back(mk(0, 2'b11, 1, 1, 32'h33333333, 2'b00, 2'b00, 1, 1, 1, 32'h22222222));
        vq.push_back(mk(0, 2'b00, 0, 0, 32'h0,        2'b00, 2'b10, 0, 0, 1, 32'h33333333));
        vq.push_back(mk(0, 2'b00, 0, 1, 32'h44444444, 2'b00, 2'b00, 0, 0, 1, 32'h33333333));
        vq.push_back(mk(0, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0, 1, 32'h33333333));
        vq.push_back(mk(0, 2'b01, 0, 0, 32'h0,        2'b01, 2'b00, 0, 0, 1, 32'h33333333));
        vq.push_back(mk(0, 2'b00, 1, 0, 32'h0,        2'b00, 2'b00, 1, 1, 0, 32'h33333333));
        vq.push_back(mk(0, 2'b00, 0, 1, 32'h55555555, 2'b00, 2'b00, 0, 1, 0, 32'h33333333));
        vq.push_back(mk(0, 2'b00, 0, 0, 32'h0,        2'b00, 2'b01, 0, 0, 0, 32'h55555555));
        vq.push_back(mk(0, 2'b10, 0, 0, 32'h0,        2'b10, 2'b00, 0, 0, 0, 32'h55555555));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 2'b01, 0, 0, 32'h0,    2'b00, 2'b00, 1, 1, 1, 32'h55555555));
        vq.push_back(mk(0, 2'b01, 1, 0, 32'h0,        2'b00, 2'b00, 1, 1, 1, 32'h55555555));
        vq.push_back(mk(0, 2'b01, 0, 0, 32'h0,        2'b00, 2'b00, 0, 1, 1, 32'h55555555));
        vq.push_back(mk(1, 2'b01, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 2'b00, 0, 1, 32'h66666666, 2'b00, 2'b00, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0));
        vq.push_back(mk(0, 2'b11, 0, 0, 32'h0,        2'b01, 2'b00, 0, 0, 0, 32'h0));

        foreach (vq[i]) begin
            @(negedge clock);
            a_rst    = vq[i].rst;
            a_valid  = vq[i].vld;
            a_srdy   = vq[i].srdy;
            a_sresp  = vq[i].sresp;
            a_srdata = vq[i].srdata;
            #1;
            chk("m_req_ready", i, 64'(a_mrdy), 64'(vq[i].e_mrdy));
            chk("m_resp_valid", i, 64'(a_rv), 64'(vq[i].e_rv));
            chk("s_req_valid", i, 64'(a_sv), 64'(vq[i].e_sv));
            chk("busy", i, 64'(a_busy), 64'(vq[i].e_busy));
            chk("grant_id", i, 64'(a_gid), 64'(vq[i].e_gid));
            chk("m_resp_rdata", i, 64'(a_rdata), 64'(vq[i].e_rdata));
            if (vq[i].e_sv) begin
                chk("s_req_addr", i, 64'(a_saddr), 64'(addr_c[vq[i].e_gid]));
                chk("s_req_wdata", i, 64'(a_swdata), 64'(wdata_c[vq[i].e_gid]));
                chk("s_req_wen", i, 64'(a_swen), 64'(wen_c[vq[i].e_gid]));
            end else if (vq[i].rst) begin
                chk("s_req_addr_rst", i, 64'(a_saddr), 64'(0));
                chk("s_req_wdata_rst", i, 64'(a_swdata), 64'(0));
                chk("s_req_wen_rst", i, 64'(a_swen), 64'(0));
            end
        end

        // Three requesters: serve req1 so ptr lands on 2, then 2 wins before 0 wraps around.
        @(negedge clock);
        b_rst = 1'b0;
        #1;
        chk("b_reset_busy", 100, 64'(b_busy), 64'(0));
        chk("b_reset_gid", 100, 64'(b_gid), 64'(0));
        b_serve(3'b010, 1, 32'hA1A1_0001, 101);
        b_serve(3'b101, 2, 32'hA1A1_0002, 102);
        b_serve(3'b101, 0, 32'hA1A1_0003, 103);
        b_serve(3'b101, 2, 32'hA1A1_0004, 104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
